codec_responder: RTL and testbench
==================================

// Module: codec_responder
// PURPOSE
// Behavioural/synthesizable model of the CODEC side of the serial audio link. It sits on the
// board-facing pins opposite codec_intf, for full-chip simulation of the equalizer.
// It receives SCLK/LRCLK/SDin/RSTn from the core and returns ADC samples on SDout.
// It captures DAC samples and exposes them to the bench or checker, one stereo pair per frame.
// PARAMETERS
// DATA_W       16  bits per channel slot, MSB first
// SYNC_STAGES   2  flops in the input synchronizer for SCLK, LRCLK, SDin and RSTn
// PORTS
// clk         in   1       system clock, 50MHz; SCLK is clk/32 and LRCLK is clk/1024
// rst_n       in   1       reset, asynchronous, active-low
// RSTn        in   1       CODEC reset from core, active low; synchronized internally
// SCLK        in   1       serial bit clock from core
// LRCLK       in   1       frame clock from core: 1 = left slot, 0 = right slot
// SDin        in   1       serial DAC data from core
// SDout       out  1       serial ADC data to core
// adc_lft     in   DATA_W  next left sample to transmit
// adc_rht     in   DATA_W  next right sample to transmit
// adc_req     out  1       1-clk pulse: adc_lft/adc_rht were just latched; bench may update them
// dac_lft     out  DATA_W  last received left sample
// dac_rht     out  DATA_W  last received right sample
// dac_vld     out  1       1-clk pulse: dac_lft/dac_rht were updated as a pair
// frm_err     out  1       sticky: a slot ended with fewer than DATA_W bits received
// BEHAVIOUR
// - Reset (rst_n low or synced RSTn low) clears all of the following: SDout, adc_req,
//   dac_lft, dac_rht, dac_vld, frm_err, the shift registers and the bit counter.
//   The state goes to IDLE. RSTn low mid-frame aborts the frame; no dac_vld is produced.
// - Inputs pass through SYNC_STAGES flops. Edge detection uses the synchronized value and
//   one extra flop. All internal events lag the pins by SYNC_STAGES+1 clk.
// - Protocol is left-justified. The core changes LRCLK and SDin on SCLK falling edges.
//   The slot MSB is valid from the LRCLK edge. The responder samples SDin on SCLK rise.
//   The responder changes SDout on SCLK fall.
// - FSM:
//   IDLE -> SYNC when RSTn is high.
//   SYNC waits for the first LRCLK rise, then goes to RUN. Bits seen before that are ignored
//   and SDout stays 0.
//   RUN -> IDLE on RSTn low.
// - LRCLK rise (RUN or SYNC->RUN):
//   - latch the adc_lft/adc_rht pair
//   - pulse adc_req the same clk
//   - load tx_shift with adc_lft so that SDout = MSB immediately
//   - clear bit_cnt and rx_shift
// - LRCLK fall: load tx_shift with the latched right sample and clear bit_cnt.
// - SCLK fall in RUN: tx_shift shifts left and SDout = the new tx_shift MSB. After DATA_W
//   bits SDout = 0 until the next LRCLK edge.
// - SCLK rise in RUN with bit_cnt < DATA_W:
//   - rx_shift = {rx_shift[DATA_W-2:0], SDin}
//   - bit_cnt++
//   - further rises in the slot are ignored; bit_cnt saturates at DATA_W
// - End of left slot (LRCLK fall): if bit_cnt == DATA_W, hold rx_shift in lft_hold;
//   else set frm_err and invalidate the frame.
// - End of right slot (LRCLK rise):
//   - if bit_cnt == DATA_W and the frame is still valid, dac_lft <= lft_hold and
//     dac_rht <= rx_shift, and dac_vld pulses 1 clk
//   - if bit_cnt < DATA_W, set frm_err and produce no dac_vld
// - An LRCLK edge and an SCLK edge in the same clk: the LRCLK action wins; the SCLK edge
//   is consumed by the load.
// - frm_err clears only on reset.
// - Latency: the right sample reaches dac_* 1 clk after the detected LRCLK rise that ends
//   the frame.
// - dac_vld and adc_req coincide on frame boundaries. This is legal.
// TESTING
// 1. rst_n low, then high with RSTn=0 for 100 clk -> all outputs 0, state IDLE, SDout 0,
//    no adc_req.
// 2. Core sends left=16'hA5C3, right=16'h1234 -> exactly one dac_vld; dac_lft=A5C3,
//    dac_rht=1234; frm_err=0.
// 3. adc_lft=16'h8001, adc_rht=16'h7FFE held, 4 frames -> core lft_in=8001, rht_in=7FFE every
//    frame; exactly one adc_req per LRCLK rise (4 pulses).
// 4. Truncate the left slot to 12 SCLKs -> frm_err=1 (sticky); no dac_vld that frame;
//    the next full frame updates dac_* normally.
// 5. Drop RSTn mid right slot, then release -> no dac_vld for the aborted frame; re-sync on
//    the next LRCLK rise; the following frame reports correct data.
// 6. Full-chip loopback with an equalizer at unity gain and a 1kHz sine on adc_* -> dac_*
//    track the filtered sine; no frm_err after 200 frames.

Source files
------------

// File: rtl/codec_responder.sv
// rtl/codec_responder.sv - CODEC-side responder for the left-justified serial audio link
module codec_responder #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RSTn,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              SDin,
  output logic              SDout,
  input  logic [DATA_W-1:0] adc_lft,
  input  logic [DATA_W-1:0] adc_rht,
  output logic              adc_req,
  output logic [DATA_W-1:0] dac_lft,
  output logic [DATA_W-1:0] dac_rht,
  output logic              dac_vld,
  output logic              frm_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, lrck_sync, sdin_sync, rstn_sync;
  logic                   sclk_d, lrck_d;
  logic [DATA_W-1:0]      tx_shift, rx_shift, lft_hold, rht_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   frame_ok;

  logic sclk_s, lrck_s, sdin_s, rstn_s;
  logic sclk_rise, sclk_fall, lr_rise, lr_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign rstn_s    = rstn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign lr_rise   = lrck_s & ~lrck_d;
  assign lr_fall   = ~lrck_s & lrck_d;

  // Bring the pins into the clk domain and keep one extra flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      lrck_sync <= '0;
      sdin_sync <= '0;
      rstn_sync <= '0;
      sclk_d    <= 1'b0;
      lrck_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], LRCLK};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], SDin};
      rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], RSTn};
      sclk_d    <= sclk_s;
      lrck_d    <= lrck_s;
    end
  end

  // Link FSM: frame sync, serial shift in/out, slot-end checks and pair hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      SDout    <= 1'b0;
      adc_req  <= 1'b0;
      dac_lft  <= '0;
      dac_rht  <= '0;
      dac_vld  <= 1'b0;
      frm_err  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      lft_hold <= '0;
      rht_q    <= '0;
      bit_cnt  <= '0;
      frame_ok <= 1'b0;
    end else if (!rstn_s) begin
      // CODEC reset from the core aborts any frame in flight
      state    <= IDLE;
      SDout    <= 1'b0;
      adc_req  <= 1'b0;
      dac_lft  <= '0;
      dac_rht  <= '0;
      dac_vld  <= 1'b0;
      frm_err  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      lft_hold <= '0;
      rht_q    <= '0;
      bit_cnt  <= '0;
      frame_ok <= 1'b0;
    end else begin
      adc_req <= 1'b0;
      dac_vld <= 1'b0;
      if (state == IDLE) begin
        state <= SYNC;
      end else if (lr_rise) begin
        // Frame boundary: close the previous frame (only if already running), open a new one
        if (state == RUN) begin
          if (bit_cnt == FULL && frame_ok) begin
            dac_lft <= lft_hold;
            dac_rht <= rx_shift;
            dac_vld <= 1'b1;
          end
          if (bit_cnt != FULL) frm_err <= 1'b1;
        end
        state    <= RUN;
        rht_q    <= adc_rht;
        adc_req  <= 1'b1;
        tx_shift <= adc_lft;
        SDout    <= adc_lft[DATA_W-1];
        rx_shift <= '0;
        bit_cnt  <= '0;
        frame_ok <= 1'b1;
      end else if (state == RUN) begin
        if (lr_fall) begin
          if (bit_cnt == FULL) begin
            lft_hold <= rx_shift;
          end else begin
            frm_err  <= 1'b1;
            frame_ok <= 1'b0;
          end
          tx_shift <= rht_q;
          SDout    <= rht_q[DATA_W-1];
          bit_cnt  <= '0;
        end else begin
          // Zero fill means SDout drops to 0 once the slot's bits are exhausted
          if (sclk_fall) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            SDout    <= tx_shift[DATA_W-2];
          end
          if (sclk_rise && bit_cnt < FULL) begin
            rx_shift <= {rx_shift[DATA_W-2:0], sdin_s};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_responder.sv
// tb/tb_codec_responder.sv - directed scoreboard bench for codec_responder
module tb_codec_responder;

  logic        clk = 1'b0;
  logic        rst_n, RSTn, SCLK, LRCLK, SDin;
  logic        SDout, adc_req, dac_vld, frm_err;
  logic [15:0] adc_lft, adc_rht, dac_lft, dac_rht;

  int n_checks = 0;
  int n_errors = 0;
  int vld_cnt  = 0;
  int req_cnt  = 0;
  int push_cnt = 0;
  logic [31:0] exp_q[$];

  codec_responder #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .RSTn(RSTn), .SCLK(SCLK), .LRCLK(LRCLK),
    .SDin(SDin), .SDout(SDout), .adc_lft(adc_lft), .adc_rht(adc_rht),
    .adc_req(adc_req), .dac_lft(dac_lft), .dac_rht(dac_rht),
    .dac_vld(dac_vld), .frm_err(frm_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: pulse counters and scoreboard pop on each delivered pair
  always @(negedge clk) begin
    logic [31:0] e;
    if (adc_req) req_cnt++;
    if (dac_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        chk("dac_vld_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("dac_lft", {16'h0, dac_lft}, {16'h0, e[31:16]});
        chk("dac_rht", {16'h0, dac_rht}, {16'h0, e[15:0]});
      end
    end
  end

  // One SCLK period as the core drives it; entered and left on a clk negedge
  task automatic sclk_cycle(input logic lr, input logic d, output logic s);
    SCLK  = 1'b0;
    LRCLK = lr;
    SDin  = d;
    repeat (16) @(negedge clk);
    s    = SDout;
    SCLK = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                            input bit abort, output logic [15:0] li, output logic [15:0] ri);
    logic s;
    li = '0;
    ri = '0;
    for (int k = 0; k < nl; k++) begin
      sclk_cycle(1'b1, l[15-k], s);
      li[15-k] = s;
    end
    for (int k = 0; k < 16; k++) begin
      if (abort && k == 8)  RSTn = 1'b0;
      if (abort && k == 10) RSTn = 1'b1;
      sclk_cycle(1'b0, r[15-k], s);
      ri[15-k] = s;
    end
  endtask

  initial begin
    logic [15:0] li, ri, l, r;
    logic        s;
    int          req0;
    rst_n = 1'b0; RSTn = 1'b0; SCLK = 1'b1; LRCLK = 1'b0; SDin = 1'b0;
    adc_lft = '0; adc_rht = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    // Reset state with the CODEC held in reset
    chk("rst_sdout",   {31'h0, SDout},   32'h0);
    chk("rst_dac_lft", {16'h0, dac_lft}, 32'h0);
    chk("rst_dac_rht", {16'h0, dac_rht}, 32'h0);
    chk("rst_frm_err", {31'h0, frm_err}, 32'h0);
    chk("rst_vld_cnt", vld_cnt, 32'd0);
    chk("rst_req_cnt", req_cnt, 32'd0);

    RSTn = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame
    send_frame(16'hA5C3, 16'h1234, 16, 1'b0, li, ri);
    exp_q.push_back({16'hA5C3, 16'h1234}); push_cnt++;
    chk("f0_lft_in", {16'h0, li}, 32'h0);

    // Held ADC pair over four frames
    adc_lft = 16'h8001; adc_rht = 16'h7FFE;
    req0 = req_cnt;
    for (int f = 0; f < 4; f++) begin
      l = 16'h1111 * 16'(f + 1);
      r = ~l;
      send_frame(l, r, 16, 1'b0, li, ri);
      exp_q.push_back({l, r}); push_cnt++;
      chk("adc_lft_in", {16'h0, li}, 32'h8001);
      chk("adc_rht_in", {16'h0, ri}, 32'h7FFE);
    end
    chk("adc_req_pulses", req_cnt - req0, 32'd4);
    chk("one_vld_basic",  vld_cnt, 32'd4);
    chk("no_err_basic",   {31'h0, frm_err}, 32'h0);

    // Truncated left slot, then two full frames
    send_frame(16'hDEAD, 16'hBEEF, 12, 1'b0, li, ri);
    chk("trunc_err", {31'h0, frm_err}, 32'h1);
    send_frame(16'h0F0F, 16'hF0F0, 16, 1'b0, li, ri);
    exp_q.push_back({16'h0F0F, 16'hF0F0}); push_cnt++;
    send_frame(16'h3C3C, 16'hC3C3, 16, 1'b0, li, ri);
    exp_q.push_back({16'h3C3C, 16'hC3C3}); push_cnt++;
    chk("trunc_err_sticky", {31'h0, frm_err}, 32'h1);
    chk("trunc_vld_cnt", vld_cnt, 32'd6);

    // CODEC reset mid right slot
    send_frame(16'h5555, 16'hAAAA, 16, 1'b1, li, ri);
    chk("abort_dac_lft", {16'h0, dac_lft}, 32'h0);
    chk("abort_dac_rht", {16'h0, dac_rht}, 32'h0);
    chk("abort_frm_err", {31'h0, frm_err}, 32'h0);
    chk("abort_vld_cnt", vld_cnt, 32'd7);
    send_frame(16'h6789, 16'h9876, 16, 1'b0, li, ri);
    exp_q.push_back({16'h6789, 16'h9876}); push_cnt++;
    send_frame(16'hFFFF, 16'h0001, 16, 1'b0, li, ri);
    exp_q.push_back({16'hFFFF, 16'h0001}); push_cnt++;

    // Random loopback frames
    for (int f = 0; f < 3; f++) begin
      adc_lft = 16'($urandom);
      adc_rht = 16'($urandom);
      l = 16'($urandom);
      r = 16'($urandom);
      send_frame(l, r, 16, 1'b0, li, ri);
      exp_q.push_back({l, r}); push_cnt++;
      chk("rnd_lft_in", {16'h0, li}, {16'h0, adc_lft});
      chk("rnd_rht_in", {16'h0, ri}, {16'h0, adc_rht});
    end

    // Trailing LRCLK rise closes the last frame
    sclk_cycle(1'b1, 1'b0, s);
    sclk_cycle(1'b1, 1'b0, s);
    chk("final_vld_cnt", vld_cnt, push_cnt);
    chk("final_q_empty", exp_q.size(), 32'd0);
    chk("final_frm_err", {31'h0, frm_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
